// File: rtl/pipe_ctrl.sv
// Pipeline control unit for the five-stage Y86 core.
// Detects load/use, mispredicted-branch and return hazards. Drives stall and
// bubble controls for the pipeline registers. Sequences the start-up flush and
// the exception halt. Keeps saturating hazard performance counters.
module pipe_ctrl #(
  parameter int FLUSH_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       D_icode_i,
  input  logic [3:0]       d_srcA_i,
  input  logic [3:0]       d_srcB_i,
  input  logic [3:0]       E_icode_i,
  input  logic [3:0]       E_dstM_i,
  input  logic             e_Cnd_i,
  input  logic [3:0]       M_icode_i,
  input  logic [2:0]       m_stat_i,
  input  logic [2:0]       W_stat_i,
  input  logic             clr_cnt_i,
  output logic             F_stall_o,
  output logic             D_stall_o,
  output logic             D_bubble_o,
  output logic             E_bubble_o,
  output logic             M_bubble_o,
  output logic             W_stall_o,
  output logic             set_cc_o,
  output logic             halted_o,
  output logic [2:0]       stat_o,
  output logic [CNT_W-1:0] loaduse_cnt_o,
  output logic [CNT_W-1:0] mispred_cnt_o,
  output logic [CNT_W-1:0] ret_cnt_o
);

  localparam logic [3:0] I_MRMOVL = 4'h5;
  localparam logic [3:0] I_OPL    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_POPL   = 4'hB;
  localparam logic [3:0] NREG     = 4'hF;
  localparam logic [2:0] SAOK     = 3'd1;

  localparam int             FCW        = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_FLUSH,
    S_RUN,
    S_HALT
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [FCW-1:0] flush_cnt;

  logic lu;
  logic mp;
  logic rt;
  logic ret_only;
  logic exc_m;
  logic exc_w;
  logic d_bubble_raw;

  // Hazard detection, purely combinational from the current pipeline contents.
  assign lu = ((E_icode_i == I_MRMOVL) || (E_icode_i == I_POPL)) &&
              (E_dstM_i != NREG) &&
              ((E_dstM_i == d_srcA_i) || (E_dstM_i == d_srcB_i));
  assign mp       = (E_icode_i == I_JXX) && !e_Cnd_i;
  assign rt       = (D_icode_i == I_RET) || (E_icode_i == I_RET) || (M_icode_i == I_RET);
  assign ret_only = !lu && rt;
  assign exc_m    = (m_stat_i != SAOK);
  assign exc_w    = (W_stat_i != SAOK);

  // A stalled decode register must hold, so its bubble request is dropped.
  assign d_bubble_raw = mp || ret_only;

  // State register and flush-cycle counter.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_FLUSH;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if ((state == S_FLUSH) && (flush_cnt != FLUSH_LAST)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end else begin
        flush_cnt <= '0;
      end
    end
  end

  // Next-state logic: flush for a fixed number of cycles, halt on a
  // writeback exception, leave halt only through reset.
  // NOTE: every combinational output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_FLUSH: if (flush_cnt == FLUSH_LAST) state_nxt = S_RUN;
      S_RUN:   if (exc_w) state_nxt = S_HALT;
      S_HALT:  state_nxt = S_HALT;
      default: state_nxt = S_FLUSH;
    endcase
  end

  // Output logic: stall/bubble/condition-code controls per state.
  always_comb begin
    F_stall_o  = 1'b0;
    D_stall_o  = 1'b0;
    D_bubble_o = 1'b0;
    E_bubble_o = 1'b0;
    M_bubble_o = 1'b0;
    W_stall_o  = 1'b0;
    set_cc_o   = 1'b0;
    halted_o   = 1'b0;
    case (state)
      S_FLUSH: begin
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
      end
      S_RUN: begin
        F_stall_o  = lu || rt;
        D_stall_o  = lu;
        D_bubble_o = d_bubble_raw && !lu;
        E_bubble_o = mp || lu;
        M_bubble_o = exc_m || exc_w;
        W_stall_o  = exc_w;
        set_cc_o   = (E_icode_i == I_OPL) && !exc_m && !exc_w;
      end
      S_HALT: begin
        F_stall_o  = 1'b1;
        D_stall_o  = 1'b1;
        W_stall_o  = 1'b1;
        M_bubble_o = 1'b1;
        halted_o   = 1'b1;
      end
      default: begin
        D_bubble_o = 1'b1;
        E_bubble_o = 1'b1;
        M_bubble_o = 1'b1;
      end
    endcase
  end

  // Architectural status: captures the writeback status on the halting edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_o <= SAOK;
    end else if ((state == S_RUN) && exc_w) begin
      stat_o <= W_stat_i;
    end
  end

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // Saturating hazard counters; clear wins over increment, count only in RUN.
  // NOTE: these are plain registers, not a memory array, so each one takes the
  // asynchronous reset directly.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loaduse_cnt_o <= '0;
      mispred_cnt_o <= '0;
      ret_cnt_o     <= '0;
    end else if (clr_cnt_i) begin
      loaduse_cnt_o <= '0;
      mispred_cnt_o <= '0;
      ret_cnt_o     <= '0;
    end else if (state == S_RUN) begin
      if (lu)       loaduse_cnt_o <= sat_inc(loaduse_cnt_o);
      if (mp)       mispred_cnt_o <= sat_inc(mispred_cnt_o);
      if (ret_only) ret_cnt_o     <= sat_inc(ret_cnt_o);
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized stimulus against a behavioural model.
module tb_pipe_ctrl;

  localparam int FC    = 3;
  localparam int CW    = 16;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    D_icode, d_srcA, d_srcB, E_icode, E_dstM, M_icode;
  logic          e_Cnd, clr_cnt;
  logic [2:0]    m_stat, W_stat;
  logic          F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted;
  logic [2:0]    stat;
  logic [CW-1:0] lu_cnt, mp_cnt, rt_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .D_icode_i(D_icode), .d_srcA_i(d_srcA), .d_srcB_i(d_srcB),
    .E_icode_i(E_icode), .E_dstM_i(E_dstM), .e_Cnd_i(e_Cnd),
    .M_icode_i(M_icode), .m_stat_i(m_stat), .W_stat_i(W_stat),
    .clr_cnt_i(clr_cnt),
    .F_stall_o(F_stall), .D_stall_o(D_stall), .D_bubble_o(D_bubble),
    .E_bubble_o(E_bubble), .M_bubble_o(M_bubble), .W_stall_o(W_stall),
    .set_cc_o(set_cc), .halted_o(halted), .stat_o(stat),
    .loaduse_cnt_o(lu_cnt), .mispred_cnt_o(mp_cnt), .ret_cnt_o(rt_cnt)
  );

  // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted}
  logic [7:0] ctrl;
  assign ctrl = {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc, halted};

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef enum int {M_FLUSH, M_RUN, M_HALT} mode_t;
  mode_t m_mode, n_mode;
  int    m_fl, n_fl;
  int    m_lu, m_mp, m_rt, n_lu, n_mp, n_rt;
  int    m_stat_q, n_stat;
  logic [7:0] last_ctrl;

  function automatic bit is_exc(input logic [2:0] s);
    return s != 3'd1;
  endfunction

  function automatic bit hz_lu();
    return (E_icode == 4'h5 || E_icode == 4'hB) && E_dstM != 4'hF &&
           (E_dstM == d_srcA || E_dstM == d_srcB);
  endfunction

  function automatic bit hz_mp();
    return E_icode == 4'h7 && !e_Cnd;
  endfunction

  function automatic bit hz_rt();
    return D_icode == 4'h9 || E_icode == 4'h9 || M_icode == 4'h9;
  endfunction

  function automatic logic [7:0] exp_ctrl();
    bit lu, mp, rt, em, ew;
    logic [7:0] r;
    lu = hz_lu(); mp = hz_mp(); rt = hz_rt();
    em = is_exc(m_stat); ew = is_exc(W_stat);
    case (m_mode)
      M_FLUSH: r = 8'b0011_1000;
      M_HALT:  r = 8'b1100_1101;
      default: begin
        r[7] = lu | rt;
        r[6] = lu;
        r[5] = lu ? 1'b0 : (mp | rt);
        r[4] = mp | lu;
        r[3] = em | ew;
        r[2] = ew;
        r[1] = (E_icode == 4'h6) && !em && !ew;
        r[0] = 1'b0;
      end
    endcase
    return r;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic model_reset();
    m_mode = M_FLUSH; m_fl = 0; m_lu = 0; m_mp = 0; m_rt = 0; m_stat_q = 1;
  endtask

  task automatic model_next();
    n_mode = m_mode; n_fl = m_fl; n_lu = m_lu; n_mp = m_mp; n_rt = m_rt; n_stat = m_stat_q;
    if (m_mode == M_FLUSH) begin
      if (m_fl == FC - 1) begin n_mode = M_RUN; n_fl = 0; end
      else n_fl = m_fl + 1;
    end else if (m_mode == M_RUN && is_exc(W_stat)) begin
      n_mode = M_HALT; n_stat = int'(W_stat);
    end
    if (clr_cnt) begin
      n_lu = 0; n_mp = 0; n_rt = 0;
    end else if (m_mode == M_RUN) begin
      if (hz_lu()) n_lu = sat(m_lu);
      if (hz_mp()) n_mp = sat(m_mp);
      if (!hz_lu() && hz_rt()) n_rt = sat(m_rt);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_ctrl"}, 32'(ctrl), 32'(exp_ctrl()));
    check({tag, "_stat"}, 32'(stat), 32'(m_stat_q));
    check({tag, "_lu"},   32'(lu_cnt), 32'(m_lu));
    check({tag, "_mp"},   32'(mp_cnt), 32'(m_mp));
    check({tag, "_rt"},   32'(rt_cnt), 32'(m_rt));
  endtask

  // One clock: check at negedge against the model, advance at posedge.
  task automatic cycle(input string tag);
    @(negedge clk);
    last_ctrl = ctrl;
    check_model(tag);
    model_next();
    @(posedge clk);
    #1;
    m_mode = n_mode; m_fl = n_fl; m_lu = n_lu; m_mp = n_mp; m_rt = n_rt; m_stat_q = n_stat;
  endtask

  task automatic nop_inputs();
    D_icode = 4'h1; d_srcA = 4'hF; d_srcB = 4'hF; E_icode = 4'h1; E_dstM = 4'hF;
    e_Cnd = 1'b0; M_icode = 4'h1; m_stat = 3'd1; W_stat = 3'd1; clr_cnt = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #2;
    model_reset();
    check("rst_ctrl", 32'(ctrl), 32'h38);
    check("rst_stat", 32'(stat), 32'd1);
    check("rst_cnt",  32'({lu_cnt, mp_cnt} | 32'(rt_cnt)), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic flush_out();
    nop_inputs();
    repeat (FC) cycle("flush");
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [3:0] d_ic, sa, sb, e_ic, dm;
    logic       cnd;
    logic [3:0] m_ic;
    logic [2:0] ms;
    logic [6:0] exp;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
  } vec_t;

  vec_t vt[12];

  initial begin
    int nb;
    vt[0]  = '{4'h1, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 7'b0000000};
    vt[1]  = '{4'h1, 4'h3, 4'hF, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 7'b1101000};
    vt[2]  = '{4'h1, 4'hF, 4'h2, 4'hB, 4'h2, 1'b0, 4'h1, 3'd1, 7'b1101000};
    vt[3]  = '{4'h1, 4'hF, 4'hF, 4'h5, 4'hF, 1'b0, 4'h1, 3'd1, 7'b0000000};
    vt[4]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h1, 3'd1, 7'b0011000};
    vt[5]  = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b1, 4'h1, 3'd1, 7'b0000000};
    vt[6]  = '{4'h9, 4'hF, 4'hF, 4'h1, 4'hF, 1'b0, 4'h1, 3'd1, 7'b1010000};
    vt[7]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd1, 7'b0000001};
    vt[8]  = '{4'h1, 4'hF, 4'hF, 4'h6, 4'hF, 1'b0, 4'h1, 3'd3, 7'b0000100};
    vt[9]  = '{4'h9, 4'h4, 4'hF, 4'h5, 4'h4, 1'b0, 4'h1, 3'd1, 7'b1101000};
    vt[10] = '{4'h1, 4'hF, 4'hF, 4'h7, 4'hF, 1'b0, 4'h9, 3'd1, 7'b1011000};
    vt[11] = '{4'h1, 4'h4, 4'h5, 4'h5, 4'h3, 1'b0, 4'h1, 3'd1, 7'b0000000};

    nop_inputs();
    rst = 1'b1;
    #1;
    do_reset();

    // Start-up flush: bubbles exactly FC cycles, then quiet controls.
    nb = 0;
    for (int i = 0; i < FC + 3; i++) begin
      cycle("boot");
      if (last_ctrl == 8'h38) nb++;
    end
    check("flush_len", 32'(nb), 32'(FC));
    check("run_quiet", 32'(last_ctrl), 32'd0);

    // Directed table, applied in RUN.
    for (int i = 0; i < 12; i++) begin
      nop_inputs();
      D_icode = vt[i].d_ic; d_srcA = vt[i].sa; d_srcB = vt[i].sb;
      E_icode = vt[i].e_ic; E_dstM = vt[i].dm; e_Cnd = vt[i].cnd;
      M_icode = vt[i].m_ic; m_stat = vt[i].ms;
      cycle("vec");
      check($sformatf("vec%0d", i), 32'(last_ctrl[7:1]), 32'(vt[i].exp));
    end

    // Load/use counter 0 -> 1.
    do_reset(); flush_out();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcA = 4'h3;
    cycle("lu1");
    nop_inputs();
    cycle("lu1b");
    check("lu_cnt_one", 32'(lu_cnt), 32'd1);

    // Return walking D -> E -> M counts three bubble cycles.
    do_reset(); flush_out();
    D_icode = 4'h9; cycle("retD");
    D_icode = 4'h1; E_icode = 4'h9; cycle("retE");
    E_icode = 4'h1; M_icode = 4'h9; cycle("retM");
    nop_inputs(); cycle("retX");
    check("ret_cnt_three", 32'(rt_cnt), 32'd3);

    // Memory exception then writeback exception -> HALT, then reset.
    do_reset(); flush_out();
    E_icode = 4'h6; m_stat = 3'd3; cycle("mexc");
    nop_inputs(); W_stat = 3'd3; cycle("wexc");
    check("halted", 32'(halted), 32'd1);
    check("halt_stat", 32'(stat), 32'd3);
    nop_inputs(); E_icode = 4'h5; E_dstM = 4'h2; d_srcA = 4'h2;
    repeat (3) cycle("halt");
    check("halt_lu_hold", 32'(lu_cnt), 32'd0);
    nop_inputs();
    do_reset();
    check("rst_halt_clr", 32'(halted), 32'd0);

    // Saturation of the load/use counter, then clear with LU still present.
    flush_out();
    E_icode = 4'h5; E_dstM = 4'h3; d_srcB = 4'h3;
    repeat ((1 << CW) + 5) @(posedge clk);
    #1;
    m_lu = CMAX;
    cycle("sat");
    check("lu_sat", 32'(lu_cnt), 32'(CMAX));
    clr_cnt = 1'b1; cycle("clr");
    check("lu_clr", 32'(lu_cnt), 32'd0);
    clr_cnt = 1'b0; cycle("post_clr");
    check("lu_after_clr", 32'(lu_cnt), 32'd1);

    // Randomized stimulus against the model.
    nop_inputs();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] regs [4];
      logic [3:0] ics  [7];
      regs = '{4'h2, 4'h3, 4'h4, 4'hF};
      ics  = '{4'h0, 4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};
      D_icode = ($urandom_range(0, 9) == 0) ? 4'($urandom) : ics[$urandom_range(0, 6)];
      E_icode = ics[$urandom_range(0, 6)];
      M_icode = ics[$urandom_range(0, 6)];
      d_srcA  = regs[$urandom_range(0, 3)];
      d_srcB  = regs[$urandom_range(0, 3)];
      E_dstM  = regs[$urandom_range(0, 3)];
      e_Cnd   = 1'($urandom);
      m_stat  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      W_stat  = ($urandom_range(0, 63) == 0) ? 3'($urandom_range(2, 4)) : 3'd1;
      clr_cnt = ($urandom_range(0, 99) == 0);
      if (m_mode == M_HALT && $urandom_range(0, 3) == 0) do_reset();
      else cycle("rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
